// File: rtl/xf_pkg.sv
// Shared widths, load-FSM states and lane helper for the XF matrix memory
// and the command decoder that feeds it.
package xf_pkg;

   localparam int XF_WORD_W      = 32;
   localparam int XF_ROW_W       = 128;
   localparam int XF_MATRIX_ROWS = 128;
   localparam int XF_LANES       = XF_ROW_W / XF_WORD_W;
   localparam int XF_LANE_W      = 2;
   localparam int XF_ROW_ADDR_W  = 7;
   localparam int XF_WADDR_W     = XF_ROW_ADDR_W + XF_LANE_W;
   localparam int XF_CNT_W       = 4;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } xf_ld_state_e;

   function automatic logic [XF_LANES-1:0] xf_lane_onehot(input logic [XF_LANE_W-1:0] lane);
      logic [XF_LANES-1:0] one;
      one = {{(XF_LANES-1){1'b0}}, 1'b1};
      return one << lane;
   endfunction

endpackage

// File: rtl/xf_matrix_ram.sv
// Simple dual-port row RAM: per-lane word writes, registered 128-bit row read.
// Contents are deliberately not reset; only the read register is.
module xf_matrix_ram
   import xf_pkg::*;
#(
   parameter int ROWS = XF_MATRIX_ROWS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en_i,
   input  logic [XF_ROW_ADDR_W-1:0] wr_row_i,
   input  logic [XF_LANES-1:0]      wr_lane_i,
   input  logic [XF_WORD_W-1:0]     wr_data_i,
   input  logic                     rd_en_i,
   input  logic [XF_ROW_ADDR_W-1:0] rd_row_i,
   output logic [XF_ROW_W-1:0]      rd_data_o
);

   logic [XF_ROW_W-1:0] mem_q [ROWS];
   logic [XF_ROW_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         for (int l = 0; l < XF_LANES; l++) begin
            if (wr_lane_i[l]) begin
               mem_q[wr_row_i][l*XF_WORD_W +: XF_WORD_W] <= wr_data_i;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= {XF_ROW_W{1'b0}};
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_row_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/xf_matrix_memory.sv
// XF matrix storage: burst word loader plus fixed-latency row read port with
// write-first bypass for a load landing on the row being read.
module xf_matrix_memory
   import xf_pkg::*;
#(
   parameter int ROWS         = XF_MATRIX_ROWS,
   parameter int READ_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ldStart,
   input  logic [XF_WADDR_W-1:0]    ldAddr,
   input  logic [XF_CNT_W-1:0]      ldCount,
   input  logic [XF_WORD_W-1:0]     ldData,
   input  logic                     ldValid,
   output logic                     ldBusy,
   output logic                     ldDone,
   input  logic [XF_ROW_ADDR_W-1:0] mpAddr,
   input  logic                     mpEnable,
   output logic [XF_ROW_W-1:0]      mpData,
   output logic                     mpValid
);

   localparam logic [XF_ROW_ADDR_W:0] ROWS_L = (XF_ROW_ADDR_W+1)'(ROWS);

   xf_ld_state_e              state_q, state_d;
   logic [XF_WADDR_W-1:0]     ptr_q, ptr_d;
   logic [XF_CNT_W-1:0]       cnt_q, cnt_d;
   logic                      done_q, done_d;

   logic                      wr_en;
   logic [XF_ROW_ADDR_W-1:0]  wr_row;
   logic [XF_LANES-1:0]       wr_lane;
   logic                      rd_in_range;
   logic [XF_ROW_W-1:0]       ram_rd_data;
   logic [XF_ROW_W-1:0]       row_merged;

   logic [READ_LATENCY-1:0]   vld_q, vld_d;
   logic [XF_LANES-1:0]       byp_mask_q;
   logic [XF_WORD_W-1:0]      byp_data_q;
   logic                      oor_q;

   // Out-of-range words are consumed and counted but never reach the RAM.
   assign wr_row      = ptr_q[XF_WADDR_W-1:XF_LANE_W];
   assign wr_lane     = xf_lane_onehot(ptr_q[XF_LANE_W-1:0]);
   assign wr_en       = (state_q == LOAD) && ldValid && !reset && ({1'b0, wr_row} < ROWS_L);
   assign rd_in_range = {1'b0, mpAddr} < ROWS_L;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= {XF_WADDR_W{1'b0}};
         cnt_q   <= {XF_CNT_W{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ldStart) begin
               ptr_d   = ldAddr;
               cnt_d   = ldCount;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (ldValid) begin
               ptr_d = ptr_q + {{(XF_WADDR_W-1){1'b0}}, 1'b1};
               if (cnt_q == {XF_CNT_W{1'b0}}) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - {{(XF_CNT_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ldBusy = (state_q == LOAD);
   assign ldDone = done_q;

   xf_matrix_ram #(.ROWS(ROWS)) u_ram (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en),
      .wr_row_i  (wr_row),
      .wr_lane_i (wr_lane),
      .wr_data_i (ldData),
      .rd_en_i   (mpEnable && rd_in_range),
      .rd_row_i  (mpAddr),
      .rd_data_o (ram_rd_data)
   );

   always_comb begin
      vld_d    = vld_q;
      vld_d[0] = mpEnable;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   // The RAM reads old data on a same-edge write, so the new lane is captured beside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q      <= {READ_LATENCY{1'b0}};
         byp_mask_q <= {XF_LANES{1'b0}};
         byp_data_q <= {XF_WORD_W{1'b0}};
         oor_q      <= 1'b0;
      end else begin
         vld_q <= vld_d;
         if (mpEnable) begin
            byp_mask_q <= (wr_en && (wr_row == mpAddr)) ? wr_lane : {XF_LANES{1'b0}};
            byp_data_q <= ldData;
            oor_q      <= !rd_in_range;
         end
      end
   end

   always_comb begin
      row_merged = ram_rd_data;
      for (int l = 0; l < XF_LANES; l++) begin
         if (byp_mask_q[l]) begin
            row_merged[l*XF_WORD_W +: XF_WORD_W] = byp_data_q;
         end else begin
            row_merged[l*XF_WORD_W +: XF_WORD_W] = ram_rd_data[l*XF_WORD_W +: XF_WORD_W];
         end
      end
      if (oor_q) begin
         row_merged = {XF_ROW_W{1'b0}};
      end else begin
         row_merged = row_merged;
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign mpData = row_merged;
      end else begin : g_latn
         logic [XF_ROW_W-1:0] dat_q [READ_LATENCY-1];

         // Each stage loads only when its request is present, so mpData holds between valids.
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int k = 0; k < READ_LATENCY-1; k++) begin
                  dat_q[k] <= {XF_ROW_W{1'b0}};
               end
            end else begin
               if (vld_q[0]) begin
                  dat_q[0] <= row_merged;
               end
               for (int k = 1; k < READ_LATENCY-1; k++) begin
                  if (vld_q[k]) begin
                     dat_q[k] <= dat_q[k-1];
                  end
               end
            end
         end

         assign mpData = dat_q[READ_LATENCY-2];
      end
   endgenerate

   assign mpValid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_xf_matrix_memory.sv
// Self-checking bench: directed scenarios plus randomized loads/reads against
// a word-array model with a queue of expected row returns.
module tb_xf_matrix_memory;

   localparam int LAT = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         ldStart;
   logic [8:0]   ldAddr;
   logic [3:0]   ldCount;
   logic [31:0]  ldData;
   logic         ldValid;
   logic         ldBusy;
   logic         ldDone;
   logic [6:0]   mpAddr;
   logic         mpEnable;
   logic [127:0] mpData;
   logic         mpValid;

   always #5 clk = ~clk;

   xf_matrix_memory #(.ROWS(128), .READ_LATENCY(LAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .ldStart  (ldStart),
      .ldAddr   (ldAddr),
      .ldCount  (ldCount),
      .ldData   (ldData),
      .ldValid  (ldValid),
      .ldBusy   (ldBusy),
      .ldDone   (ldDone),
      .mpAddr   (mpAddr),
      .mpEnable (mpEnable),
      .mpData   (mpData),
      .mpValid  (mpValid)
   );

   typedef struct {
      int           due;
      logic [127:0] row;
   } rd_t;

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   logic [31:0]  mem_m [512];
   rd_t          rdq[$];
   bit           busy_m = 1'b0;
   bit           done_m = 1'b0;
   int           ptr_m = 0;
   int           rem_m = 0;
   logic [127:0] last_m = '0;
   bit           rd_rand = 1'b0;
   logic [31:0]  wq[$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [127:0] row_of(input int r);
      return {mem_m[r*4+3], mem_m[r*4+2], mem_m[r*4+1], mem_m[r*4]};
   endfunction

   // One clock: apply this cycle's inputs to the model, advance, compare outputs.
   task automatic tick();
      bit busy_n;
      busy_n = busy_m;
      done_m = 1'b0;
      if (rd_rand) begin
         mpEnable = 1'($urandom_range(0, 1));
         mpAddr   = 7'($urandom);
      end
      if (reset) begin
         busy_n = 1'b0;
         rdq.delete();
         last_m = '0;
      end else begin
         if (busy_m && ldValid) begin
            mem_m[ptr_m] = ldData;
            ptr_m = (ptr_m + 1) % 512;
            if (rem_m == 0) begin
               busy_n = 1'b0;
               done_m = 1'b1;
            end else begin
               rem_m--;
            end
         end else if (!busy_m && ldStart) begin
            busy_n = 1'b1;
            ptr_m  = int'(ldAddr);
            rem_m  = int'(ldCount);
         end
         if (mpEnable) begin
            rdq.push_back('{cyc + LAT, row_of(int'(mpAddr))});
         end
      end
      busy_m = busy_n;
      @(posedge clk);
      #1;
      cyc++;
      chk("ldBusy", {127'd0, ldBusy}, {127'd0, busy_m});
      chk("ldDone", {127'd0, ldDone}, {127'd0, done_m});
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
         chk("mpValid", {127'd0, mpValid}, 128'd1);
         chk("mpData", mpData, rdq[0].row);
         last_m = rdq[0].row;
         void'(rdq.pop_front());
      end else begin
         chk("mpValid_idle", {127'd0, mpValid}, 128'd0);
         chk("mpData_hold", mpData, last_m);
      end
   endtask

   // Burst of cnt+1 words with 'gap' idle cycles before each word; data from wq, else random.
   task automatic burst(input int addr, input int cnt, input int gap, input bit noise);
      ldStart = 1'b1;
      ldAddr  = 9'(addr);
      ldCount = 4'(cnt);
      tick();
      ldStart = 1'b0;
      for (int i = 0; i <= cnt; i++) begin
         for (int g = 0; g < gap; g++) begin
            ldValid = 1'b0;
            if (noise) begin
               ldStart = 1'b1;
               ldAddr  = 9'($urandom);
            end
            tick();
         end
         ldValid = 1'b1;
         ldData  = (wq.size() > 0) ? wq.pop_front() : $urandom;
         if (noise) begin
            ldStart = 1'b1;
            ldAddr  = 9'($urandom);
         end
         tick();
      end
      ldValid = 1'b0;
      ldStart = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; ldStart = 1'b0; ldAddr = '0; ldCount = '0; ldData = '0;
      ldValid = 1'b0; mpAddr = '0; mpEnable = 1'b0;
      idle(3);
      reset = 1'b0;
      idle(2);

      // Fill every word so later reads compare defined data; bursts run back-to-back.
      for (int b = 0; b < 32; b++) begin
         burst(b * 16, 15, 0, 1'b0);
      end
      idle(2);

      // Single 4-word load then row 0 read.
      wq = '{32'h3F800000, 32'h0, 32'h0, 32'h0};
      burst(0, 3, 0, 1'b0);
      mpEnable = 1'b1; mpAddr = 7'd0;
      tick();
      mpEnable = 1'b0;
      tick();
      chk("t1_row0", mpData, 128'h00000000_00000000_00000000_3F800000);
      idle(2);

      // Wrapping 16-word burst, then five back-to-back row reads.
      burst(9'h1FE, 15, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         mpEnable = 1'b1;
         mpAddr   = (i == 0) ? 7'd127 : 7'(i - 1);
         tick();
      end
      mpEnable = 1'b0;
      idle(LAT + 1);

      // Write-first collision on row 5 lane 2; next-cycle write to lane 3 stays invisible.
      ldStart = 1'b1; ldAddr = 9'h016; ldCount = 4'd1;
      tick();
      ldStart = 1'b0;
      ldValid = 1'b1; ldData = 32'hDEADBEEF; mpEnable = 1'b1; mpAddr = 7'd5;
      tick();
      ldData = 32'h12345678; mpEnable = 1'b0;
      tick();
      ldValid = 1'b0;
      chk("t3_lane2", {96'd0, mpData[95:64]}, 128'hDEADBEEF);
      idle(2);

      // ldStart noise during LOAD must be ignored.
      burst(9'h080, 5, 1, 1'b1);
      idle(2);

      // Reset mid-load with two reads in flight.
      ldStart = 1'b1; ldAddr = 9'h040; ldCount = 4'd7;
      tick();
      ldStart = 1'b0;
      ldValid = 1'b1; mpEnable = 1'b1; mpAddr = 7'h10;
      ldData = 32'hA5A5_0001;
      tick();
      ldData = 32'hA5A5_0002;
      tick();
      reset = 1'b1; ldData = 32'hFFFF_FFFF;
      tick();
      reset = 1'b0; ldValid = 1'b0; mpEnable = 1'b0;
      idle(3);
      mpEnable = 1'b1; mpAddr = 7'h10;
      tick();
      mpEnable = 1'b0;
      tick();
      chk("t5_words", {64'd0, mpData[63:0]}, 128'hA5A50002_A5A50001);
      idle(2);

      // Sparse ldValid: one word every third cycle.
      burst(9'h120, 4, 2, 1'b0);
      idle(2);

      // Randomized loads with concurrent random reads.
      rd_rand = 1'b1;
      for (int b = 0; b < 40; b++) begin
         burst(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            idle(int'($urandom_range(1, 3)));
         end
      end
      rd_rand = 1'b0;
      mpEnable = 1'b0;
      idle(LAT + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
